monochrome_pipeline: RTL and testbench

Registered, pixel-enable-qualified colour stage between the core's RGB/sync outputs and `vga_scandoubler`. It converts 6-bit-per-gun RGB to luma and maps it onto one of three monochrome phosphor palettes, or passes colour through. It delays the three syncs by the same latency so they stay aligned with the pixels. Palette changes take effect only at a frame boundary (vsync leading edge), so a switch never tears the picture mid-frame.

---
 rtl/monochrome_pipeline_pkg.sv | 30 +++
 rtl/monochrome_pipeline_if.sv | 22 ++
 rtl/monochrome_pipeline_luma_palette_map.sv | 41 ++++
 rtl/monochrome_pipeline.sv | 93 +++++++++
 tb/tb_monochrome_pipeline.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/monochrome_pipeline_pkg.sv
// Shared video definitions: colour width, luma weights, palette codes, sync bundle.
package monochrome_pipeline_pkg;

  localparam int unsigned CW     = 6;
  localparam int unsigned SUM_W  = 14;
  localparam int unsigned LUMA_R = 77;
  localparam int unsigned LUMA_G = 150;
  localparam int unsigned LUMA_B = 29;

  typedef enum logic [1:0] {
    MODE_COLOUR = 2'b00,
    MODE_GREEN  = 2'b01,
    MODE_AMBER  = 2'b10,
    MODE_WHITE  = 2'b11
  } mode_e;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic cs_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, cs_n: 1'b1};

  // Amber green gun is ~3/4 of luma; never exceeds Y, so no carry out of CW bits.
  function automatic logic [CW-1:0] amber_green(input logic [CW-1:0] y);
    return (y >> 1) + (y >> 2);
  endfunction

endpackage

// File: rtl/monochrome_pipeline_if.sv
// Pixel bus between the core colour outputs, this stage and the scandoubler.
interface monochrome_pipeline_if #(
  parameter int unsigned CW = monochrome_pipeline_pkg::CW
);
  logic          clken;
  logic [1:0]    mode;
  logic [CW-1:0] ri, gi, bi;
  logic          hsync_n_in, vsync_n_in, csync_n_in;
  logic [CW-1:0] ro, go, bo;
  logic          hsync_n_out, vsync_n_out, csync_n_out;
  logic [1:0]    mode_active;

  modport slave (
    input  clken, mode, ri, gi, bi, hsync_n_in, vsync_n_in, csync_n_in,
    output ro, go, bo, hsync_n_out, vsync_n_out, csync_n_out, mode_active
  );

  modport master (
    output clken, mode, ri, gi, bi, hsync_n_in, vsync_n_in, csync_n_in,
    input  ro, go, bo, hsync_n_out, vsync_n_out, csync_n_out, mode_active
  );
endinterface

// File: rtl/monochrome_pipeline_luma_palette_map.sv
// Combinational map from luma / raw RGB to output guns for the selected palette.
module monochrome_pipeline_luma_palette_map
  import monochrome_pipeline_pkg::*;
#(
  parameter int unsigned PW = monochrome_pipeline_pkg::CW
) (
  input  logic [PW-1:0] y_i,
  input  logic [PW-1:0] r_i,
  input  logic [PW-1:0] g_i,
  input  logic [PW-1:0] b_i,
  input  mode_e         mode_i,
  output logic [PW-1:0] r_c,
  output logic [PW-1:0] g_c,
  output logic [PW-1:0] b_c
);

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    unique case (mode_i)
      MODE_COLOUR: begin
        r_c = r_i;
        g_c = g_i;
        b_c = b_i;
      end
      MODE_GREEN: g_c = y_i;
      MODE_AMBER: begin
        r_c = y_i;
        g_c = (y_i >> 1) + (y_i >> 2);
      end
      MODE_WHITE: begin
        r_c = y_i;
        g_c = y_i;
        b_c = y_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/monochrome_pipeline.sv
// Two-stage pixel-enabled colour/monochrome stage with frame-aligned palette switching.
module monochrome_pipeline
  import monochrome_pipeline_pkg::*;
#(
  parameter int unsigned CW = monochrome_pipeline_pkg::CW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  monochrome_pipeline_if.slave  bus
);

  mode_e             mode_active_q, mode1_q;
  logic              vs_prev_q;
  logic              frame_edge_c;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic [CW-1:0]     r1_q, g1_q, b1_q;
  sync_t             sync_in_c, sync1_q, sync2_q;
  logic [CW-1:0]     y_c, map_r_c, map_g_c, map_b_c;
  logic [CW-1:0]     ro_q, go_q, bo_q;
  logic              unused_sum_lsb_c;

  assign sync_in_c    = '{hs_n: bus.hsync_n_in, vs_n: bus.vsync_n_in, cs_n: bus.csync_n_in};
  assign frame_edge_c = bus.clken & vs_prev_q & ~bus.vsync_n_in;
  assign sum_d        = SUM_W'(LUMA_R * 32'(bus.ri) + LUMA_G * 32'(bus.gi) + LUMA_B * 32'(bus.bi));

  // Palette latch: only a vsync leading edge on a pixel-enabled cycle loads a new mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q     <= 1'b1;
      mode_active_q <= MODE_COLOUR;
    end else if (bus.clken) begin
      vs_prev_q <= bus.vsync_n_in;
      if (frame_edge_c) mode_active_q <= mode_e'(bus.mode);
    end
  end

  // Stage 1: weighted luma sum plus raw colour, syncs and the palette in force.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      sync1_q <= SYNC_IDLE;
      mode1_q <= MODE_COLOUR;
    end else if (bus.clken) begin
      sum_q   <= sum_d;
      r1_q    <= bus.ri;
      g1_q    <= bus.gi;
      b1_q    <= bus.bi;
      sync1_q <= sync_in_c;
      mode1_q <= mode_active_q;
    end
  end

  assign y_c              = sum_q[SUM_W-1 -: CW];
  assign unused_sum_lsb_c = ^sum_q[SUM_W-CW-1:0];

  monochrome_pipeline_luma_palette_map #(.PW(CW)) u_map (
    .y_i    (y_c),
    .r_i    (r1_q),
    .g_i    (g1_q),
    .b_i    (b1_q),
    .mode_i (mode1_q),
    .r_c    (map_r_c),
    .g_c    (map_g_c),
    .b_c    (map_b_c)
  );

  // Stage 2: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_q    <= '0;
      go_q    <= '0;
      bo_q    <= '0;
      sync2_q <= SYNC_IDLE;
    end else if (bus.clken) begin
      ro_q    <= map_r_c;
      go_q    <= map_g_c;
      bo_q    <= map_b_c;
      sync2_q <= sync1_q;
    end
  end

  assign bus.ro          = ro_q;
  assign bus.go          = go_q;
  assign bus.bo          = bo_q;
  assign bus.hsync_n_out = sync2_q.hs_n;
  assign bus.vsync_n_out = sync2_q.vs_n;
  assign bus.csync_n_out = sync2_q.cs_n;
  assign bus.mode_active = mode_active_q;

endmodule

// File: tb/tb_monochrome_pipeline.sv
// Directed bench: reset, latency, palette table, frame-boundary switching, stall and async reset.
module tb_monochrome_pipeline;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  monochrome_pipeline_if #(.CW(6)) bus ();

  monochrome_pipeline dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] mode;
    logic [5:0] r, g, b;
    logic [5:0] er, eg, eb;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rgb(input string name, input logic [5:0] er, input logic [5:0] eg,
                           input logic [5:0] eb);
    check(name, 32'({bus.ro, bus.go, bus.bo}), 32'({er, eg, eb}));
  endtask

  task automatic check_idle(input string name);
    check_rgb({name, "_rgb"}, 6'd0, 6'd0, 6'd0);
    check({name, "_sync"}, 32'({bus.hsync_n_out, bus.vsync_n_out, bus.csync_n_out}), 32'd7);
    check({name, "_mode"}, 32'(bus.mode_active), 32'd0);
  endtask

  task automatic step(input logic en);
    bus.clken = en;
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    bus.ri = r;
    bus.gi = g;
    bus.bi = b;
  endtask

  task automatic frame_edge(input logic [1:0] m);
    bus.mode       = m;
    bus.vsync_n_in = 1'b0;
    step(1'b1);
    bus.vsync_n_in = 1'b1;
    step(1'b1);
  endtask

  initial begin
    logic [1:0] cur_mode;
    logic [1:0] tog [6];

    vecs[0]  = '{2'd0, 6'd21, 6'd42, 6'd63, 6'd21, 6'd42, 6'd63};
    vecs[1]  = '{2'd0, 6'd5,  6'd6,  6'd7,  6'd5,  6'd6,  6'd7 };
    vecs[2]  = '{2'd1, 6'd0,  6'd63, 6'd0,  6'd0,  6'd36, 6'd0 };
    vecs[3]  = '{2'd1, 6'd63, 6'd63, 6'd63, 6'd0,  6'd63, 6'd0 };
    vecs[4]  = '{2'd2, 6'd0,  6'd63, 6'd30, 6'd40, 6'd30, 6'd0 };
    vecs[5]  = '{2'd2, 6'd63, 6'd63, 6'd63, 6'd63, 6'd46, 6'd0 };
    vecs[6]  = '{2'd3, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63};
    vecs[7]  = '{2'd3, 6'd63, 6'd0,  6'd0,  6'd18, 6'd18, 6'd18};
    vecs[8]  = '{2'd3, 6'd0,  6'd0,  6'd63, 6'd7,  6'd7,  6'd7 };
    vecs[9]  = '{2'd3, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0 };
    vecs[10] = '{2'd3, 6'd0,  6'd63, 6'd0,  6'd36, 6'd36, 6'd36};
    tog      = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};

    rst_n          = 1'b1;
    bus.clken      = 1'b0;
    bus.mode       = 2'd0;
    pix(6'd0, 6'd0, 6'd0);
    bus.hsync_n_in = 1'b1;
    bus.vsync_n_in = 1'b1;
    bus.csync_n_in = 1'b1;

    // Reset with busy inputs and clken toggling.
    #2 rst_n = 1'b0;
    pix(6'd63, 6'd31, 6'd17);
    bus.hsync_n_in = 1'b0;
    bus.vsync_n_in = 1'b0;
    bus.csync_n_in = 1'b0;
    bus.mode       = 2'd3;
    #1 check_idle("reset_async");
    for (int i = 0; i < 5; i++) begin
      step(1'(i % 2));
      check_idle($sformatf("reset_hold%0d", i));
    end
    pix(6'd0, 6'd0, 6'd0);
    bus.hsync_n_in = 1'b1;
    bus.vsync_n_in = 1'b1;
    bus.csync_n_in = 1'b1;
    bus.mode       = 2'd0;
    rst_n          = 1'b1;

    // Pass-through latency with clken every second clock.
    pix(6'd21, 6'd42, 6'd63);
    bus.hsync_n_in = 1'b0;
    step(1'b1);
    check_rgb("lat_c1", 6'd0, 6'd0, 6'd0);
    pix(6'd0, 6'd0, 6'd0);
    bus.hsync_n_in = 1'b1;
    step(1'b0);
    check_rgb("lat_c2", 6'd0, 6'd0, 6'd0);
    check("lat_c2_hs", 32'(bus.hsync_n_out), 32'd1);
    step(1'b1);
    check_rgb("lat_c3", 6'd21, 6'd42, 6'd63);
    check("lat_c3_hs", 32'(bus.hsync_n_out), 32'd0);
    step(1'b0);
    check_rgb("lat_c4", 6'd21, 6'd42, 6'd63);
    step(1'b1);
    check_rgb("lat_c5", 6'd0, 6'd0, 6'd0);
    check("lat_c5_hs", 32'(bus.hsync_n_out), 32'd1);

    // Palette table.
    cur_mode = 2'd0;
    foreach (vecs[i]) begin
      if (vecs[i].mode != cur_mode) begin
        frame_edge(vecs[i].mode);
        cur_mode = vecs[i].mode;
        check($sformatf("tbl%0d_mode", i), 32'(bus.mode_active), 32'(cur_mode));
      end
      pix(vecs[i].r, vecs[i].g, vecs[i].b);
      step(1'b1);
      step(1'b1);
      check_rgb($sformatf("tbl%0d_rgb", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
    end

    // Mid-frame request is deferred to the vsync edge.
    frame_edge(2'd0);
    bus.mode = 2'd1;
    pix(6'd10, 6'd20, 6'd30);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("defer_mode", 32'(bus.mode_active), 32'd0);
    end
    check_rgb("defer_rgb", 6'd10, 6'd20, 6'd30);
    pix(6'd11, 6'd22, 6'd33);
    bus.vsync_n_in = 1'b0;
    step(1'b1);
    check("edge_mode", 32'(bus.mode_active), 32'd1);
    pix(6'd0, 6'd63, 6'd0);
    step(1'b1);
    check_rgb("edge_pixel_colour", 6'd11, 6'd22, 6'd33);
    pix(6'd0, 6'd0, 6'd0);
    bus.vsync_n_in = 1'b1;
    step(1'b1);
    check_rgb("post_edge_green", 6'd0, 6'd36, 6'd0);

    // Toggling the request within a frame is invisible.
    pix(6'd63, 6'd63, 6'd63);
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.mode = tog[i];
      step(1'b1);
      check_rgb($sformatf("toggle%0d_rgb", i), 6'd0, 6'd63, 6'd0);
      check($sformatf("toggle%0d_mode", i), 32'(bus.mode_active), 32'd1);
    end

    // Stall: everything frozen, a vsync pulse while clken is low is not an edge.
    pix(6'd1, 6'd2, 6'd3);
    bus.hsync_n_in = 1'b0;
    bus.mode       = 2'd3;
    for (int i = 0; i < 10; i++) begin
      bus.vsync_n_in = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      step(1'b0);
      check_rgb($sformatf("stall%0d_rgb", i), 6'd0, 6'd63, 6'd0);
      check($sformatf("stall%0d_hs", i), 32'(bus.hsync_n_out), 32'd1);
    end
    bus.vsync_n_in = 1'b1;
    step(1'b1);
    check_rgb("resume1_rgb", 6'd0, 6'd63, 6'd0);
    check("resume1_mode", 32'(bus.mode_active), 32'd1);
    step(1'b1);
    check_rgb("resume2_rgb", 6'd0, 6'd1, 6'd0);
    check("resume2_hs", 32'(bus.hsync_n_out), 32'd0);
    check("resume2_mode", 32'(bus.mode_active), 32'd1);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1 check_idle("async_mid");
    @(posedge clk);
    #1 check_idle("async_hold");
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
